// File: rtl/register_file.sv
// 32 x 32-bit register file with a hardware clear sequence after reset.
// It has two combinational read ports with write-through bypass and one write port.
module register_file (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        reg_write_i,
    input  logic [4:0]  write_reg_i,
    input  logic [31:0] write_data_i,
    input  logic [4:0]  read_reg1_i,
    input  logic [4:0]  read_reg2_i,
    output logic [31:0] read_data1_o,
    output logic [31:0] read_data2_o,
    output logic        busy_o,
    output logic        dbg_state_o,
    output logic [4:0]  dbg_clear_idx_o
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic [4:0]  clear_idx_q;
    logic [4:0]  clear_idx_d;
    logic [31:0] regs_q [32];

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        user_wr;

    // A user write is only live in READY; register 0 is hard-wired to zero.
    assign user_wr = (state_q == READY) && reg_write_i && (write_reg_i != 5'd0);

    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        wr_en       = 1'b0;
        wr_addr     = write_reg_i;
        wr_data     = write_data_i;
        case (state_q)
            CLEAR: begin
                wr_en       = 1'b1;
                wr_addr     = clear_idx_q;
                wr_data     = 32'd0;
                clear_idx_d = clear_idx_q + 5'd1;
                if (clear_idx_q == 5'd31) begin
                    state_d = READY;
                end
            end
            READY: begin
                wr_en = user_wr;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= CLEAR;
            clear_idx_q <= 5'd0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
        end
    end

    // The array has no reset of its own; the clear sequence zeroes it.
    always_ff @(posedge clock_i) begin
        if (!reset_i && wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        if (state_q != READY) begin
            read_data1_o = 32'd0;
        end else if (user_wr && (write_reg_i == read_reg1_i)) begin
            read_data1_o = write_data_i;
        end else if (read_reg1_i == 5'd0) begin
            read_data1_o = 32'd0;
        end else begin
            read_data1_o = regs_q[read_reg1_i];
        end
    end

    always_comb begin
        if (state_q != READY) begin
            read_data2_o = 32'd0;
        end else if (user_wr && (write_reg_i == read_reg2_i)) begin
            read_data2_o = write_data_i;
        end else if (read_reg2_i == 5'd0) begin
            read_data2_o = 32'd0;
        end else begin
            read_data2_o = regs_q[read_reg2_i];
        end
    end

    assign busy_o          = (state_q == CLEAR);
    assign dbg_state_o     = state_q;
    assign dbg_clear_idx_o = clear_idx_q;

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: directed vector table, clear/reset corner sequences,
// and random traffic checked against an array-based reference model.
module tb_register_file;

    logic        clk;
    logic        reset_i;
    logic        reg_write_i;
    logic [4:0]  write_reg_i;
    logic [31:0] write_data_i;
    logic [4:0]  read_reg1_i;
    logic [4:0]  read_reg2_i;
    logic [31:0] read_data1_o;
    logic [31:0] read_data2_o;
    logic        busy_o;
    logic        dbg_state_o;
    logic [4:0]  dbg_clear_idx_o;

    register_file dut (
        .clock_i         (clk),
        .reset_i         (reset_i),
        .reg_write_i     (reg_write_i),
        .write_reg_i     (write_reg_i),
        .write_data_i    (write_data_i),
        .read_reg1_i     (read_reg1_i),
        .read_reg2_i     (read_reg2_i),
        .read_data1_o    (read_data1_o),
        .read_data2_o    (read_data2_o),
        .busy_o          (busy_o),
        .dbg_state_o     (dbg_state_o),
        .dbg_clear_idx_o (dbg_clear_idx_o)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: register contents plus remaining clear cycles
    logic [31:0] mem [32];
    int          busy_cnt;
    bit          model_valid;

    int          vectors;
    int          miscompares;
    logic        s_busy;
    logic [31:0] s_rd1;
    logic [31:0] s_rd2;

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] rr);
        if (busy_cnt > 0) return 32'd0;
        if (reg_write_i && write_reg_i != 5'd0 && write_reg_i == rr) return write_data_i;
        if (rr == 5'd0) return 32'd0;
        return mem[rr];
    endfunction

    // driver: apply one cycle of inputs, check outputs at negedge, advance model at posedge
    task automatic cycle(input logic rst, input logic we, input logic [4:0] wr,
                         input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        reset_i      = rst;
        reg_write_i  = we;
        write_reg_i  = wr;
        write_data_i = wd;
        read_reg1_i  = r1;
        read_reg2_i  = r2;
        @(negedge clk);
        s_busy = busy_o;
        s_rd1  = read_data1_o;
        s_rd2  = read_data2_o;
        if (model_valid) begin
            chk("busy", {31'd0, busy_o}, {31'd0, busy_cnt > 0});
            chk("read_data1", read_data1_o, model_read(r1));
            chk("read_data2", read_data2_o, model_read(r2));
        end
        @(posedge clk);
        if (rst) begin
            busy_cnt    = 32;
            model_valid = 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                for (int i = 0; i < 32; i++) mem[i] = 32'd0;
            end
        end else if (we && wr != 5'd0) begin
            mem[wr] = wd;
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    endtask

    // counts busy cycles after the current point, bounded
    task automatic count_busy(input string name, input int exp_cycles);
        int n;
        n = 0;
        for (int i = 0; i < 80; i++) begin
            idle();
            if (!s_busy) break;
            n++;
        end
        chk(name, n, exp_cycles);
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 1'b0, 5'd0, 32'd0, i[4:0], 5'(31 - i));
            chk(name, s_rd1, 32'd0);
            chk(name, s_rd2, 32'd0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        busy_cnt    = 0;
        model_valid = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;

        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0,        32'h0};
        tbl[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd5, 32'h0,        32'hDEADBEEF};
        tbl[4] = '{1'b1, 5'd7, 32'h12345678, 5'd7, 5'd8, 32'h12345678, 32'h0};
        tbl[5] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd8, 32'h12345678, 32'h0};
        tbl[6] = '{1'b1, 5'd8, 32'hCAFEF00D, 5'd8, 5'd8, 32'hCAFEF00D, 32'hCAFEF00D};
        tbl[7] = '{1'b1, 5'd9, 32'h00000001, 5'd9, 5'd7, 32'h00000001, 32'h12345678};

        reset_i = 1'b1; reg_write_i = 1'b0; write_reg_i = '0; write_data_i = '0;
        read_reg1_i = '0; read_reg2_i = '0;
        @(posedge clk); #1;

        // one reset cycle, then exactly 32 busy cycles and an all-zero file
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        count_busy("busy_len_after_reset", 32);
        read_all_zero("zero_after_clear");

        // directed table in READY
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].r1, tbl[i].r2);
            chk("tbl_rd1", s_rd1, tbl[i].e1);
            chk("tbl_rd2", s_rd2, tbl[i].e2);
        end

        // write attempt at clear index 10 must be ignored
        cycle(1'b0, 1'b1, 5'd3, 32'h13579BDF, 5'd3, 5'd3);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        for (int i = 0; i < 10; i++) idle();
        cycle(1'b0, 1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'd3);
        chk("clear_write_busy", {31'd0, s_busy}, 32'd1);
        chk("clear_write_rd", s_rd1, 32'd0);
        count_busy("busy_rest_after_idx10", 21);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
        chk("reg3_after_ignored_write", s_rd1, 32'd0);

        // reset pulsed at clear index 20 restarts a full 32-cycle clear
        cycle(1'b0, 1'b1, 5'd31, 32'h5A5A5A5A, 5'd0, 5'd0);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        for (int i = 0; i < 20; i++) idle();
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        count_busy("busy_len_after_midreset", 32);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd31);
        chk("reg31_after_midreset", s_rd1, 32'd0);

        // fill 1..31 with index, reset (with a write pending), all must read back 0
        for (int i = 1; i < 32; i++) cycle(1'b0, 1'b1, i[4:0], i, 5'd0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd17, 5'd31);
        chk("fill_reg17", s_rd1, 32'd17);
        chk("fill_reg31", s_rd2, 32'd31);
        cycle(1'b1, 1'b1, 5'd4, 32'hFFFF0000, 5'd0, 5'd0);
        count_busy("busy_len_after_fill_reset", 32);
        read_all_zero("zero_after_fill_reset");

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        for (int i = 0; i < 40; i++) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameters: none; widths fixed at 32-bit data, 5-bit register address, 32 registers.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high; starts the clear sequence.
REQ-005 reg_write  input  1  write enable for the write port.
REQ-006 write_reg  input  5  write address; driven by the rt/rd destination select.
REQ-007 write_data  input  32  write data; driven by the ALU/memory writeback select.
REQ-008 read_reg1  input  5  read address, port 1 (rs).
REQ-009 read_reg2  input  5  read address, port 2 (rt).
REQ-010 read_data1  output  32  read data, port 1.
REQ-011 read_data2  output  32  read data, port 2.
REQ-012 busy  output  1  high while the clear sequence runs; writes are ignored while high.

Function
REQ-013 Storage SHALL be 32 registers of 32 bits, indices 0..31.
REQ-014 The state machine SHALL have exactly two states: CLEAR and READY.
REQ-015 busy SHALL be 1 in CLEAR and 0 in READY, decoded from state only.
REQ-016 A 5-bit clear_idx SHALL count through the register file during CLEAR.
REQ-017 Each non-reset edge in CLEAR SHALL write 0 to reg[clear_idx] and increment clear_idx.
REQ-018 On the CLEAR edge with clear_idx==31, the block SHALL clear reg[31] and enter READY; clear_idx wraps to 0.
REQ-019 Clear sequence length SHALL be exactly 32 non-reset edges after reset deasserts.
REQ-020 In READY, a rising edge with reg_write=1 and write_reg!=0 SHALL store write_data into reg[write_reg].
REQ-021 A write to register 0 SHALL be discarded; reg[0] always reads 0.
REQ-022 In CLEAR, reg_write SHALL be ignored, whatever write_reg and write_data are.
REQ-023 Reads SHALL be combinational (zero-cycle latency) from read_reg1 and read_reg2.
REQ-024 Both read ports SHALL be independent; equal addresses return identical data.
REQ-025 While busy=1, read_data1 and read_data2 SHALL both be 0.
REQ-026 Write-through bypass in READY: if reg_write=1, write_reg!=0 and write_reg==read_regN, read_dataN SHALL equal write_data in the same cycle.
REQ-027 Bypass SHALL apply to each port independently and simultaneously.
REQ-028 The block SHALL contain no latches; all outputs are fully defined for every input combination.

Reset
REQ-029 reset=1 at a rising edge SHALL set state to CLEAR and clear_idx to 0, and SHALL perform no register write that edge.
REQ-030 Reset asserted mid-CLEAR SHALL restart the sequence at index 0, followed by a full 32 edges.
REQ-031 Reset asserted in READY with reg_write=1 SHALL discard that write.
REQ-032 After reset deassertion, busy SHALL stay 1 for exactly 32 cycles; the first accepted write is on edge 33.
REQ-033 Register contents before reset completes are undefined; outputs are 0 while busy.

Verification
REQ-034 Reset 1 cycle, then idle -> busy=1 for 32 cycles, falls after the 32nd edge; every register reads 0 on both ports.
REQ-035 READY: write reg 5=0xDEADBEEF, next cycle read_reg1=5, read_reg2=5 -> both 0xDEADBEEF; write reg 0=0xFFFFFFFF -> read reg 0 = 0.
REQ-036 Same cycle reg_write=1, write_reg=7, write_data=0x12345678, read_reg1=7, read_reg2=8 -> read_data1=0x12345678 (bypass), read_data2=old reg 8.
REQ-037 During CLEAR at index 10: reg_write=1, write_reg=3, data 0xAAAA5555 -> ignored; after READY, reg 3 reads 0.
REQ-038 Pulse reset at clear_idx=20 -> busy stays 1 for 32 more cycles; reg 31 reads 0 afterwards.
REQ-039 Fill regs 1..31 with their index, then reset -> after busy falls, all registers read 0.
